// File: rtl/q2b_sweep_pkg.sv
// Shared types and default sizes for the q2b truth-table sweeper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package q2b_sweep_pkg;

  localparam int N_IN_DFLT = 4;
  localparam int TBL_W     = 2 ** N_IN_DFLT;
  localparam int CNT_W     = N_IN_DFLT + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } sweep_state_t;

endpackage

// File: rtl/q2b_sweep_ctrl_if.sv
// Bundle between the test/config master, the sweeper and the q2b datapath.
// Latency: n/a (wires only).
// Backpressure: none; start is a level sampled only while the sweeper is idle.
interface q2b_sweep_ctrl_if
  import q2b_sweep_pkg::*;
#(
  parameter int N_IN = N_IN_DFLT
);

  localparam int TW = 2 ** N_IN;
  localparam int CW = N_IN + 1;

  logic            start;
  logic            abort;
  logic [TW-1:0]   exp_tbl;
  logic            f_in;
  logic [N_IN-1:0] abcd_out;
  logic            busy;
  logic            done;
  logic [TW-1:0]   truth_tbl;
  logic [CW-1:0]   ones_cnt;
  logic            mismatch;

  // Config master plus the q2b output it forwards.
  modport master (
    output start, abort, exp_tbl, f_in,
    input  abcd_out, busy, done, truth_tbl, ones_cnt, mismatch
  );

  // Sweeper side.
  modport slave (
    input  start, abort, exp_tbl, f_in,
    output abcd_out, busy, done, truth_tbl, ones_cnt, mismatch
  );

endinterface

// File: rtl/q2b_settle_timer.sv
// Loadable down-counter that times how long each vector is held before sampling.
// Latency: zero flag reflects the registered count (load/decrement visible next cycle).
// Backpressure: none; load has priority over decrement, count saturates at zero.
module q2b_settle_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  // Reload on request, otherwise count down while enabled and non-zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/q2b_sweep_ctrl.sv
// Exhaustive sweeper for q2b: drives every input vector, captures f, counts ones, compares.
// Latency: SETTLE+1 cycles per vector; done pulses the cycle after edge E0 + 2^N_IN*(SETTLE+1).
// Backpressure: start ignored while busy; abort cancels synchronously and wins over everything.
module q2b_sweep_ctrl
  import q2b_sweep_pkg::*;
#(
  parameter int N_IN   = N_IN_DFLT,
  parameter int SETTLE = 1
) (
  input logic          clk,
  input logic          rst_n,
  q2b_sweep_ctrl_if.slave bus
);

  localparam int TW    = 2 ** N_IN;
  localparam int CW    = N_IN + 1;
  localparam int TMR_W = $clog2(SETTLE) + 1;

  localparam logic [TMR_W-1:0] RELOAD   = TMR_W'(SETTLE - 1);
  localparam logic [N_IN-1:0]  LAST_IDX = {N_IN{1'b1}};

  sweep_state_t    state_q;
  logic [N_IN-1:0] idx_q;
  logic [N_IN-1:0] abcd_q;
  logic            busy_q;
  logic            done_q;
  logic [TW-1:0]   tbl_q;
  logic [TW-1:0]   tbl_d;
  logic [CW-1:0]   ones_q;
  logic            mism_q;
  logic [TW-1:0]   exp_q;

  logic tmr_load;
  logic tmr_en;
  logic tmr_zero;

  // The timer is armed when a sweep starts and again after every non-final sample.
  assign tmr_load = ((state_q == ST_IDLE)   && bus.start && !bus.abort) ||
                    ((state_q == ST_SAMPLE) && !bus.abort && (idx_q != LAST_IDX));
  assign tmr_en   = (state_q == ST_SETTLE);

  q2b_settle_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (RELOAD),
    .en_i       (tmr_en),
    .zero_o     (tmr_zero)
  );

  // Table as it will look once the current sample lands; the final compare uses it.
  always_comb begin
    tbl_d        = tbl_q;
    tbl_d[idx_q] = bus.f_in;
  end

  // Sweep FSM with registered vector, status and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      abcd_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tbl_q   <= '0;
      ones_q  <= '0;
      mism_q  <= 1'b0;
      exp_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start && !bus.abort) begin
            tbl_q   <= '0;
            ones_q  <= '0;
            mism_q  <= 1'b0;
            exp_q   <= bus.exp_tbl;
            idx_q   <= '0;
            abcd_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (bus.abort) begin
            abcd_q  <= '0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else if (tmr_zero) begin
            state_q <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          if (bus.abort) begin
            abcd_q  <= '0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            tbl_q  <= tbl_d;
            ones_q <= ones_q + CW'(bus.f_in);
            if (idx_q == LAST_IDX) begin
              mism_q  <= |(tbl_d ^ exp_q);
              done_q  <= 1'b1;
              abcd_q  <= '0;
              state_q <= ST_DONE;
            end else begin
              idx_q   <= idx_q + N_IN'(1);
              abcd_q  <= idx_q + N_IN'(1);
              state_q <= ST_SETTLE;
            end
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          abcd_q  <= '0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.abcd_out  = abcd_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.truth_tbl = tbl_q;
  assign bus.ones_cnt  = ones_q;
  assign bus.mismatch  = mism_q;

endmodule

// File: tb/tb_q2b_sweep_ctrl.sv
// Bench for q2b_sweep_ctrl: two instances (SETTLE=1 and SETTLE=3) fed by q2b function models.
// Latency: checks every cycle of each sweep against the vector-timing rules.
// Backpressure: exercises ignored restarts, aborts, reset mid-sweep and start+abort in idle.
module tb_q2b_sweep_ctrl;

  logic        clk;
  logic        rst_n;
  logic        sel;
  logic        start_v;
  logic        abort_v;
  logic [15:0] exp_v;
  logic [15:0] rtbl;
  int          fmode;
  int          checks;
  int          errors;

  logic [3:0]  o_abcd;
  logic        o_busy;
  logic        o_done;
  logic [15:0] o_tbl;
  logic [4:0]  o_ones;
  logic        o_mism;

  q2b_sweep_ctrl_if #(.N_IN(4)) if1 ();
  q2b_sweep_ctrl_if #(.N_IN(4)) if3 ();

  q2b_sweep_ctrl #(.N_IN(4), .SETTLE(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  q2b_sweep_ctrl #(.N_IN(4), .SETTLE(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

  // q2b function models: 0 const0, 1 const1, 2 a&b, 3 d, otherwise random table.
  function automatic logic f_of(input int mode, input logic [3:0] v);
    case (mode)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return v[3] & v[2];
      3:       return v[0];
      default: return rtbl[v];
    endcase
  endfunction

  assign if1.start   = start_v & ~sel;
  assign if3.start   = start_v & sel;
  assign if1.abort   = abort_v & ~sel;
  assign if3.abort   = abort_v & sel;
  assign if1.exp_tbl = exp_v;
  assign if3.exp_tbl = exp_v;
  assign if1.f_in    = f_of(fmode, if1.abcd_out);
  assign if3.f_in    = f_of(fmode, if3.abcd_out);

  always_comb begin
    o_abcd = sel ? if3.abcd_out  : if1.abcd_out;
    o_busy = sel ? if3.busy      : if1.busy;
    o_done = sel ? if3.done      : if1.done;
    o_tbl  = sel ? if3.truth_tbl : if1.truth_tbl;
    o_ones = sel ? if3.ones_cnt  : if1.ones_cnt;
    o_mism = sel ? if3.mismatch  : if1.mismatch;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // All outputs of the selected instance must be zero.
  task automatic check_zero(input string nm);
    checks++; if (o_abcd !== 4'h0)     begin errors++; $display("FAIL %s abcd got %0h want 0", nm, o_abcd); end
    checks++; if (o_busy !== 1'b0)     begin errors++; $display("FAIL %s busy got %0b want 0", nm, o_busy); end
    checks++; if (o_done !== 1'b0)     begin errors++; $display("FAIL %s done got %0b want 0", nm, o_done); end
    checks++; if (o_tbl  !== 16'h0000) begin errors++; $display("FAIL %s tbl got %04h want 0000", nm, o_tbl); end
    checks++; if (o_ones !== 5'd0)     begin errors++; $display("FAIL %s ones got %0d want 0", nm, o_ones); end
    checks++; if (o_mism !== 1'b0)     begin errors++; $display("FAIL %s mism got %0b want 0", nm, o_mism); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_v = 1'b0; abort_v = 1'b0; exp_v = '0; fmode = 0; rtbl = '0; sel = 1'b0;
    #12;
    check_zero("reset_s1");
    sel = 1'b1; #1;
    check_zero("reset_s3");
    sel = 1'b0;
    #9 rst_n = 1'b1;
    tick();
    check_zero("post_reset");
  endtask

  // Full sweep: per-cycle vector/busy/done timing, then final results against the model.
  task automatic test_sweep(input logic s, input int S, input int mode, input logic [15:0] exp,
                            input int repulse, input string nm);
    int          per;
    int          total;
    logic [15:0] rt;
    int          ro;
    logic        rm;
    logic [3:0]  e_abcd;
    per   = S + 1;
    total = 16 * per;
    rt    = '0;
    for (int i = 0; i < 16; i++) rt[i] = f_of(mode, 4'(i));
    ro = $countones(rt);
    rm = (rt != exp);
    sel = s; fmode = mode; exp_v = exp; start_v = 1'b1;
    tick();
    start_v = 1'b0;
    exp_v   = ~exp;
    checks++; if (o_busy !== 1'b1)     begin errors++; $display("FAIL %s busy@E0 got %0b want 1", nm, o_busy); end
    checks++; if (o_mism !== 1'b0)     begin errors++; $display("FAIL %s mism@E0 got %0b want 0", nm, o_mism); end
    checks++; if (o_tbl  !== 16'h0000) begin errors++; $display("FAIL %s tbl@E0 got %04h want 0000", nm, o_tbl); end
    checks++; if (o_ones !== 5'd0)     begin errors++; $display("FAIL %s ones@E0 got %0d want 0", nm, o_ones); end
    checks++; if (o_abcd !== 4'h0)     begin errors++; $display("FAIL %s abcd@E0 got %0h want 0", nm, o_abcd); end
    for (int k = 1; k <= total + 2; k++) begin
      start_v = (k == repulse);
      tick();
      start_v = 1'b0;
      e_abcd  = (k < total) ? 4'(k / per) : 4'h0;
      checks++; if (o_abcd !== e_abcd) begin errors++; $display("FAIL %s abcd@E0+%0d got %0h want %0h", nm, k, o_abcd, e_abcd); end
      checks++; if (o_busy !== (k <= total)) begin errors++; $display("FAIL %s busy@E0+%0d got %0b want %0b", nm, k, o_busy, (k <= total)); end
      checks++; if (o_done !== (k == total)) begin errors++; $display("FAIL %s done@E0+%0d got %0b want %0b", nm, k, o_done, (k == total)); end
      if (k == total) begin
        checks++; if (o_mism !== rm) begin errors++; $display("FAIL %s mism@done got %0b want %0b", nm, o_mism, rm); end
      end
    end
    checks++; if (o_tbl  !== rt)     begin errors++; $display("FAIL %s tbl got %04h want %04h", nm, o_tbl, rt); end
    checks++; if (o_ones !== 5'(ro)) begin errors++; $display("FAIL %s ones got %0d want %0d", nm, o_ones, ro); end
    checks++; if (o_mism !== rm)     begin errors++; $display("FAIL %s mism held got %0b want %0b", nm, o_mism, rm); end
  endtask

  // Abort sampled at edge E0+m: only vectors whose sample edge precedes m are captured.
  task automatic test_abort(input logic s, input int S, input int mode, input int m, input string nm);
    int          per;
    int          n;
    logic [15:0] rt;
    int          ro;
    per = S + 1;
    n   = (m - 1) / per;
    rt  = '0;
    for (int i = 0; i < n; i++) rt[i] = f_of(mode, 4'(i));
    ro = $countones(rt);
    sel = s; fmode = mode; exp_v = ~rt; start_v = 1'b1;
    tick();
    start_v = 1'b0;
    for (int k = 1; k < m; k++) tick();
    abort_v = 1'b1;
    tick();
    abort_v = 1'b0;
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL %s busy after abort got %0b want 0", nm, o_busy); end
    checks++; if (o_abcd !== 4'h0) begin errors++; $display("FAIL %s abcd after abort got %0h want 0", nm, o_abcd); end
    for (int k = 0; k < 16 * per + 4; k++) begin
      tick();
      checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL %s done after abort got %0b want 0", nm, o_done); end
    end
    checks++; if (o_tbl  !== rt)     begin errors++; $display("FAIL %s tbl got %04h want %04h", nm, o_tbl, rt); end
    checks++; if (o_ones !== 5'(ro)) begin errors++; $display("FAIL %s ones got %0d want %0d", nm, o_ones, ro); end
    checks++; if (o_mism !== 1'b0)   begin errors++; $display("FAIL %s mism got %0b want 0", nm, o_mism); end
    checks++; if (o_busy !== 1'b0)   begin errors++; $display("FAIL %s busy later got %0b want 0", nm, o_busy); end
  endtask

  // Asynchronous reset between edges mid-sweep; no resume afterwards.
  task automatic test_reset_mid();
    sel = 1'b0; fmode = 1; exp_v = '0; start_v = 1'b1;
    tick();
    start_v = 1'b0;
    for (int k = 1; k < 20; k++) tick();
    #3 rst_n = 1'b0;
    #1;
    check_zero("rst_mid");
    #10 rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick();
      checks++; if (o_busy !== 1'b0 || o_done !== 1'b0) begin
        errors++; $display("FAIL rst_resume busy/done got %0b/%0b want 0/0", o_busy, o_done);
      end
    end
  endtask

  // start and abort together in idle: abort wins, nothing starts.
  task automatic test_idle_both();
    sel = 1'b0; fmode = 1; start_v = 1'b1; abort_v = 1'b1;
    tick();
    start_v = 1'b0; abort_v = 1'b0;
    check_zero("idle_both");
    tick();
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL idle_both later busy got %0b want 0", o_busy); end
  endtask

  task automatic test_random();
    logic s;
    int   m;
    for (int it = 0; it < 4; it++) begin
      rtbl = 16'($urandom);
      s    = 1'($urandom_range(0, 1));
      test_sweep(s, s ? 3 : 1, 4, ($urandom_range(0, 1) == 1) ? rtbl : 16'($urandom), 0, "rand_sweep");
    end
    for (int it = 0; it < 2; it++) begin
      rtbl = 16'($urandom);
      m    = $urandom_range(2, 31);
      test_abort(1'b0, 1, 4, m, "rand_abort");
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_sweep(1'b0, 1, 0, 16'h0000, 0, "zero");
    test_sweep(1'b0, 1, 2, 16'hF000, 0, "and_ok");
    test_sweep(1'b0, 1, 2, 16'hF001, 0, "and_mis");
    test_sweep(1'b0, 1, 2, 16'hF000, 6, "restart_ign");
    test_abort(1'b0, 1, 1, 11, "abort_e10");
    rtbl = 16'h5A3C;
    test_abort(1'b0, 1, 4, 32, "abort_last");
    test_reset_mid();
    test_idle_both();
    test_sweep(1'b1, 3, 3, 16'hAAAA, 0, "settle3");
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
